// File: rtl/ad_pkg.sv
// Shared types and widths for the load-cell weighing slice (ad_mavg, ad_weight).
package ad_pkg;
  localparam int unsigned RAW_W    = 24;
  localparam int unsigned WEIGHT_W = 16;
  localparam logic [WEIGHT_W-1:0] WEIGHT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    FILL,
    RUN,
    TARE
  } ad_state_e;
endpackage

// File: rtl/ad_weight_if.sv
// Sample-in / weight-out bundle between the HX711 reader, ad_weight and the canteen logic.
interface ad_weight_if;
  import ad_pkg::*;

  logic [RAW_W-1:0]    raw_value;
  logic                raw_valid;
  logic                tare_req;
  logic [WEIGHT_W-1:0] weight_g;
  logic                weight_valid;
  logic                overload;
  logic                stable;
  logic                tare_busy;

  modport master (
    output raw_value, raw_valid, tare_req,
    input  weight_g, weight_valid, overload, stable, tare_busy
  );

  modport slave (
    input  raw_value, raw_valid, tare_req,
    output weight_g, weight_valid, overload, stable, tare_busy
  );
endinterface

// File: rtl/ad_mavg.sv
// Moving average over 2^AVG_LOG2 raw samples: ring buffer, pointer, fill counter, accumulator.
module ad_mavg
  import ad_pkg::*;
#(
  parameter int unsigned AVG_LOG2 = 3
) (
  input  logic             clk_50,
  input  logic             rst,
  input  logic             raw_valid,
  input  logic [RAW_W-1:0] raw_value,
  output logic [RAW_W-1:0] avg,
  output logic             filled
);
  localparam int unsigned N     = 1 << AVG_LOG2;
  localparam int unsigned ACC_W = RAW_W + AVG_LOG2;

  logic [RAW_W-1:0]        ring [N];
  logic [AVG_LOG2-1:0]     ptr;
  logic [AVG_LOG2:0]       fill_cnt;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] add_v;
  logic signed [ACC_W-1:0] sub_v;
  logic [RAW_W-1:0]        oldest;

  // fill_cnt stops at N = 2^AVG_LOG2, so its MSB alone marks a full ring
  assign filled = fill_cnt[AVG_LOG2];
  assign oldest = filled ? ring[ptr] : '0;
  assign add_v  = {{AVG_LOG2{raw_value[RAW_W-1]}}, raw_value};
  assign sub_v  = {{AVG_LOG2{oldest[RAW_W-1]}}, oldest};
  assign avg    = RAW_W'(acc >>> AVG_LOG2);

  always_ff @(posedge clk_50) begin
    if (rst) begin
      ptr      <= '0;
      fill_cnt <= '0;
      acc      <= '0;
    end else if (raw_valid) begin
      acc <= acc + add_v - sub_v;
      ptr <= ptr + AVG_LOG2'(1);
      if (!filled) fill_cnt <= fill_cnt + (AVG_LOG2 + 1)'(1);
    end
  end

  always_ff @(posedge clk_50) begin
    if (raw_valid) ring[ptr] <= raw_value;
  end
endmodule

// File: rtl/ad_weight.sv
// HX711 post-processing: moving average, tare, gain/shift, clamp to 16-bit grams.
// Stability detection is built only when AD_WEIGHT_STABLE_EN is defined; otherwise stable = 1.
module ad_weight
  import ad_pkg::*;
#(
  parameter int unsigned AVG_LOG2    = 3,
  parameter logic [15:0] SCALE_NUM   = 16'd1,
  parameter int unsigned SCALE_SHIFT = 0,
  parameter logic [15:0] STABLE_TH   = 16'd2,
  parameter int unsigned STABLE_CNT  = 8
) (
  input  logic        clk_50,
  input  logic        rst,
  ad_weight_if.slave  bus
);
  localparam int unsigned DIFF_W = RAW_W + 1;
  localparam int unsigned PROD_W = DIFF_W + 16;

  ad_state_e                state, state_d;
  logic                     tare_pend;
  logic                     tare_ld;
  logic [AVG_LOG2-1:0]      tare_cnt;
  logic [RAW_W-1:0]         avg;
  logic [RAW_W-1:0]         tare;
  logic                     filled;
  logic                     smp_q;
  logic                     emit_q;
  logic signed [DIFF_W-1:0] diff;
  logic signed [PROD_W-1:0] prod, prod_q, res;
  logic [WEIGHT_W-1:0]      w_next;
  logic                     o_next;

  ad_mavg #(.AVG_LOG2(AVG_LOG2)) u_mavg (
    .clk_50    (clk_50),
    .rst       (rst),
    .raw_valid (bus.raw_valid),
    .raw_value (bus.raw_value),
    .avg       (avg),
    .filled    (filled)
  );

  assign diff = {avg[RAW_W-1], avg} - {tare[RAW_W-1], tare};
  // Low PROD_W bits of an unsigned multiply equal the signed product at this width
  assign prod = {{16{diff[DIFF_W-1]}}, diff} * {{DIFF_W{1'b0}}, SCALE_NUM};
  assign res  = prod_q >>> SCALE_SHIFT;

  always_comb begin
    w_next = res[WEIGHT_W-1:0];
    o_next = 1'b0;
    if (res[PROD_W-1]) begin
      w_next = '0;
    end else if (|res[PROD_W-2:WEIGHT_W]) begin
      w_next = WEIGHT_MAX;
      o_next = 1'b1;
    end
  end

  always_comb begin
    state_d = state;
    unique case (state)
      FILL:    if (filled) state_d = RUN;
      RUN:     if (bus.tare_req || tare_pend) state_d = TARE;
      TARE:    if (tare_ld) state_d = RUN;
      default: state_d = FILL;
    endcase
  end

  assign bus.tare_busy = (state == TARE);

  // A sample's output eligibility is fixed by the state in its own cycle; the ring-full
  // check happens one cycle later so the sample that completes the fill is emitted.
  always_ff @(posedge clk_50) begin
    if (rst) begin
      state            <= FILL;
      tare_pend        <= 1'b0;
      tare_cnt         <= '0;
      tare_ld          <= 1'b0;
      tare             <= '0;
      smp_q            <= 1'b0;
      emit_q           <= 1'b0;
      prod_q           <= '0;
      bus.weight_valid <= 1'b0;
      bus.weight_g     <= '0;
      bus.overload     <= 1'b0;
    end else begin
      state <= state_d;
      if (state == FILL && bus.tare_req) tare_pend <= 1'b1;
      else if (state == RUN)             tare_pend <= 1'b0;
      if (state != TARE)      tare_cnt <= '0;
      else if (bus.raw_valid) tare_cnt <= tare_cnt + AVG_LOG2'(1);
      tare_ld <= (state == TARE) && bus.raw_valid && (tare_cnt == '1);
      if (tare_ld) tare <= avg;
      smp_q            <= bus.raw_valid && (state != TARE);
      emit_q           <= smp_q && filled;
      prod_q           <= prod;
      bus.weight_valid <= emit_q;
      if (emit_q) begin
        bus.weight_g <= w_next;
        bus.overload <= o_next;
      end
    end
  end

`ifdef AD_WEIGHT_STABLE_EN
  localparam int unsigned SC_W = $clog2(STABLE_CNT + 1);
  localparam logic [SC_W-1:0] SC_MAX = SC_W'(STABLE_CNT);

  logic [SC_W-1:0]     stab_cnt;
  logic [WEIGHT_W-1:0] prev_w;
  logic [WEIGHT_W-1:0] w_delta;

  assign w_delta = (bus.weight_g >= prev_w) ? bus.weight_g - prev_w : prev_w - bus.weight_g;

  always_ff @(posedge clk_50) begin
    if (rst) begin
      stab_cnt <= '0;
      prev_w   <= '0;
    end else begin
      if (bus.weight_valid) prev_w <= bus.weight_g;
      if (state == RUN && state_d == TARE) begin
        stab_cnt <= '0;
      end else if (bus.weight_valid) begin
        if (w_delta <= STABLE_TH) begin
          if (stab_cnt != SC_MAX) stab_cnt <= stab_cnt + SC_W'(1);
        end else begin
          stab_cnt <= '0;
        end
      end
    end
  end

  assign bus.stable = (stab_cnt == SC_MAX);
`else
  logic unused_stab;
  assign unused_stab = ^{STABLE_TH, STABLE_CNT};
  assign bus.stable  = 1'b1;
`endif
endmodule

// File: tb/tb_ad_weight.sv
// Bench for ad_weight: vector table with a latency-stamped scoreboard, two gain settings.
module tb_ad_weight;
`ifdef AD_WEIGHT_STABLE_EN
  localparam bit STAB_EN = 1'b1;
`else
  localparam bit STAB_EN = 1'b0;
`endif

  logic clk_50 = 1'b0;
  logic rst    = 1'b1;
  always #10 clk_50 = ~clk_50;

  ad_weight_if bus ();
  ad_weight_if bus2 ();

  ad_weight #(
    .AVG_LOG2(2), .SCALE_NUM(16'd1), .SCALE_SHIFT(0), .STABLE_TH(16'd2), .STABLE_CNT(3)
  ) dut (.clk_50(clk_50), .rst(rst), .bus(bus));

  ad_weight #(
    .AVG_LOG2(2), .SCALE_NUM(16'd100), .SCALE_SHIFT(0), .STABLE_TH(16'd2), .STABLE_CNT(3)
  ) dut2 (.clk_50(clk_50), .rst(rst), .bus(bus2));

  typedef struct {
    int raw; bit tare; bit emit; int w; bit o; int w2; bit o2; bit stab; bit busy;
  } vec_t;
  typedef struct { int w; bit o; int cyc; } exp_t;

  vec_t tbl[$];
  exp_t q1[$];
  exp_t q2[$];
  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk_50) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(int raw, bit tare, bit emit, int w, bit o, int w2, bit o2,
                              bit stab, bit busy);
    vec_t v;
    v = '{raw, tare, emit, w, o, w2, o2, stab, busy};
    return v;
  endfunction

  function automatic void add(int raw, bit tare, bit emit, int w, bit o, int w2, bit o2,
                              bit stab, bit busy);
    tbl.push_back(mk(raw, tare, emit, w, o, w2, o2, stab, busy));
  endfunction

  task automatic drive(input vec_t v, input string tag);
    bus.raw_value  = 24'(v.raw);
    bus.raw_valid  = 1'b1;
    bus.tare_req   = v.tare;
    bus2.raw_value = 24'(v.raw);
    bus2.raw_valid = 1'b1;
    bus2.tare_req  = v.tare;
    if (v.emit) begin
      q1.push_back('{v.w, v.o, cyc + 3});
      q2.push_back('{v.w2, v.o2, cyc + 3});
    end
    @(negedge clk_50);
    bus.raw_valid  = 1'b0;
    bus.tare_req   = 1'b0;
    bus2.raw_valid = 1'b0;
    bus2.tare_req  = 1'b0;
    repeat (4) @(negedge clk_50);
    check({tag, " stable"}, int'(bus.stable), STAB_EN ? int'(v.stab) : 1);
    check({tag, " tare_busy"}, int'(bus.tare_busy), int'(v.busy));
  endtask

  task automatic pulse_tare();
    bus.tare_req  = 1'b1;
    bus2.tare_req = 1'b1;
    @(negedge clk_50);
    bus.tare_req  = 1'b0;
    bus2.tare_req = 1'b0;
  endtask

  always @(negedge clk_50) begin : mon1
    exp_t e;
    if (!rst && bus.weight_valid) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut1 unexpected weight_valid: got weight_g=%0d, expected no output",
                 bus.weight_g);
      end else begin
        e = q1.pop_front();
        check("dut1 weight_g", int'(bus.weight_g), e.w);
        check("dut1 overload", int'(bus.overload), int'(e.o));
        check("dut1 latency", cyc, e.cyc);
      end
    end
  end

  always @(negedge clk_50) begin : mon2
    exp_t e;
    if (!rst && bus2.weight_valid) begin
      if (q2.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut2 unexpected weight_valid: got weight_g=%0d, expected no output",
                 bus2.weight_g);
      end else begin
        e = q2.pop_front();
        check("dut2 weight_g", int'(bus2.weight_g), e.w);
        check("dut2 overload", int'(bus2.overload), int'(e.o));
        check("dut2 latency", cyc, e.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected the run to complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.raw_value  = '0;
    bus.raw_valid  = 1'b0;
    bus.tare_req   = 1'b0;
    bus2.raw_value = '0;
    bus2.raw_valid = 1'b0;
    bus2.tare_req  = 1'b0;
    repeat (3) @(negedge clk_50);
    check("reset weight_g", int'(bus.weight_g), 0);
    check("reset weight_valid", int'(bus.weight_valid), 0);
    check("reset overload", int'(bus.overload), 0);
    check("reset tare_busy", int'(bus.tare_busy), 0);
    check("reset stable", int'(bus.stable), STAB_EN ? 0 : 1);
    rst = 1'b0;

    //   raw  tare emit  w   o   w2    o2 stab busy
    add(100,  0, 0,    0, 0,     0, 0, 0, 0);
    add(100,  0, 0,    0, 0,     0, 0, 0, 0);
    add(100,  0, 0,    0, 0,     0, 0, 0, 0);
    add(100,  0, 1,  100, 0, 10000, 0, 0, 0);
    add(200,  0, 1,  125, 0, 12500, 0, 0, 0);
    add(200,  0, 1,  150, 0, 15000, 0, 0, 0);
    add(1000, 0, 1,  375, 0, 37500, 0, 0, 0);
    add(1000, 0, 1,  600, 0, 60000, 0, 0, 0);
    add(1000, 0, 1,  800, 0, 65535, 1, 0, 0);
    add(1000, 0, 1, 1000, 0, 65535, 1, 0, 0);
    add(1000, 0, 1, 1000, 0, 65535, 1, 0, 0);
    add(1000, 1, 1, 1000, 0, 65535, 1, 0, 1);
    add(1000, 0, 0,    0, 0,     0, 0, 0, 1);
    add(1000, 0, 0,    0, 0,     0, 0, 0, 1);
    add(1000, 0, 0,    0, 0,     0, 0, 0, 1);
    add(1000, 0, 0,    0, 0,     0, 0, 0, 0);
    add(1000, 0, 1,    0, 0,     0, 0, 0, 0);
    add(1010, 0, 1,    2, 0,   200, 0, 0, 0);
    add(1010, 0, 1,    5, 0,   500, 0, 0, 0);
    add(1010, 0, 1,    7, 0,   700, 0, 0, 0);
    add(1010, 0, 1,   10, 0,  1000, 0, 0, 0);
    add(1010, 0, 1,   10, 0,  1000, 0, 0, 0);
    add(1010, 0, 1,   10, 0,  1000, 0, 0, 0);
    add(1010, 0, 1,   10, 0,  1000, 0, 1, 0);
    add(1210, 0, 1,   60, 0,  6000, 0, 0, 0);
    add(900,  0, 1,   32, 0,  3200, 0, 0, 0);
    add(900,  0, 1,    5, 0,   500, 0, 0, 0);
    add(900,  0, 1,    0, 0,     0, 0, 0, 0);
    add(900,  0, 1,    0, 0,     0, 0, 0, 0);
    add(1400, 0, 1,   25, 0,  2500, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) drive(tbl[i], $sformatf("vec%0d", i + 1));

    // Reset while a tare capture is in progress
    pulse_tare();
    check("midtare tare_busy", int'(bus.tare_busy), 1);
    rst = 1'b1;
    @(negedge clk_50);
    rst = 1'b0;
    check("rst weight_g", int'(bus.weight_g), 0);
    check("rst weight_valid", int'(bus.weight_valid), 0);
    check("rst overload", int'(bus.overload), 0);
    check("rst tare_busy", int'(bus.tare_busy), 0);
    check("rst stable", int'(bus.stable), STAB_EN ? 0 : 1);
    check("rst dut2 weight_g", int'(bus2.weight_g), 0);

    // Refill from empty with a tare request latched during FILL
    drive(mk(500, 0, 0, 0, 0, 0, 0, 0, 0), "refill1");
    pulse_tare();
    check("fill tare latched, busy", int'(bus.tare_busy), 0);
    drive(mk(500, 0, 0,   0, 0,     0, 0, 0, 0), "refill2");
    drive(mk(500, 0, 0,   0, 0,     0, 0, 0, 0), "refill3");
    drive(mk(500, 0, 1, 500, 0, 50000, 0, 0, 1), "refill4");
    drive(mk(500, 0, 0,   0, 0,     0, 0, 0, 1), "refill5");
    drive(mk(500, 0, 0,   0, 0,     0, 0, 0, 1), "refill6");
    drive(mk(500, 0, 0,   0, 0,     0, 0, 0, 1), "refill7");
    drive(mk(500, 0, 0,   0, 0,     0, 0, 0, 0), "refill8");
    drive(mk(600, 0, 1,  25, 0,  2500, 0, 0, 0), "refill9");

    repeat (5) @(negedge clk_50);
    check("dut1 outputs outstanding", q1.size(), 0);
    check("dut2 outputs outstanding", q2.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ad_weight.md
# ad_weight

Post-processing stage fed directly by the HX711 load-cell reader: it takes each new 24-bit signed raw conversion, computes a moving average over 2^AVG_LOG2 samples, subtracts a tare offset, and scales the result to grams. It outputs an unsigned 16-bit saturated weight, an overload flag and a stability flag. Its outputs go to the canteen controller's weighing and pricing logic.

## Interface
- AVG_LOG2, 3: moving-average depth N = 2^AVG_LOG2; legal range 1..5.
- SCALE_NUM, 16'd1: unsigned 16-bit gain numerator.
- SCALE_SHIFT, 0: right shift applied after the multiply; legal range 0..24.
- STABLE_TH, 16'd2: maximum difference in grams between consecutive outputs that still counts as "stable".
- STABLE_CNT, 8: number of consecutive stable outputs required before `stable` asserts.
- clk_50  in  1  system clock, 50 MHz.
- rst  in  1  synchronous reset, active-high.
- raw_value  in  24  HX711 conversion, two's complement.
- raw_valid  in  1  one-cycle strobe marking that raw_value holds a new sample.
- tare_req  in  1  one-cycle request to zero the scale.
- weight_g  out  16  scaled weight in grams, saturated.
- weight_valid  out  1  one-cycle strobe marking that weight_g has been updated.
- overload  out  1  scaled result exceeded 65535; registered with weight_g.
- stable  out  1  weight has settled.
- tare_busy  out  1  a tare capture is in progress.

## Operation
- FSM states: FILL, RUN, TARE.
- **FILL** (entered after reset):
  - Each accepted sample is written to the ring and added to the accumulator; the evicted value counts as 0.
  - Moves to RUN once N samples have been accepted.
  - No weight_valid is produced in FILL.
- **RUN:**
  - Each sample updates `acc <= acc + new - oldest`.
  - avg = acc >>> AVG_LOG2 (arithmetic shift).
  - Each sample produces one weight_valid.
- **TARE:**
  - Entered from RUN on tare_req.
  - tare_busy = 1 and weight_valid is suppressed.
  - After N further accepted samples, the tare register is loaded with avg and the FSM returns to RUN.
- tare_req during FILL is latched; TARE starts on the first cycle in RUN.
- tare_req during TARE is ignored.
- Arithmetic, per sample:
  - acc is 24+AVG_LOG2 bits, signed.
  - diff = avg − tare, 25 bits, signed.
  - prod = diff × SCALE_NUM, 41 bits, signed.
  - res = prod >>> SCALE_SHIFT.
  - If res < 0: weight_g = 0 and overload = 0.
  - If res > 65535: weight_g = 65535 and overload = 1.
  - Otherwise weight_g = res[15:0] and overload = 0.
- Stability (computed on each weight_valid):
  - If |weight_g − previous weight_g| ≤ STABLE_TH, the counter increments, saturating at STABLE_CNT.
  - Otherwise the counter is cleared.
  - stable = (counter == STABLE_CNT).
  - Entering TARE clears the counter, and stable goes to 0.
- raw_valid coinciding with tare_req: the sample is processed under the current state; the tare request takes effect on the next cycle.

## Timing
- Reset values:
  - weight_g = 0, weight_valid = 0, overload = 0, stable = 0, tare_busy = 0.
  - tare register = 0, acc = 0, ring pointer = 0, fill count = 0.
  - FSM in FILL.
- Reset applied mid-operation discards all buffered samples and the tare value; the next N samples refill the ring.
- Latency: raw_valid at cycle T gives weight_valid at T+3.
  - T+1: accumulator update.
  - T+2: subtract and multiply.
  - T+3: shift, clamp and register.
- stable updates at T+4.
- Throughput: one sample every 2 cycles or slower. HX711 samples arrive at intervals of ≥ 1 ms, so samples are never back-to-back.
- tare_busy asserts the cycle after tare_req is accepted. It deasserts in the cycle the tare register loads.

## Configuration
- `AD_WEIGHT_STABLE_EN` defined: the stability counter and threshold logic are present; `stable` behaves as described above.
- Not defined: the stability logic is omitted, `stable` is tied to 1, and STABLE_TH and STABLE_CNT are unused.

## Structure
- Shared package `ad_pkg`:
  - FSM state enum (FILL, RUN, TARE).
  - RAW_W = 24 and WEIGHT_W = 16.
  - Saturation constant WEIGHT_MAX = 16'hFFFF.
- Sub-module `ad_mavg`:
  - Contains the ring buffer (N × 24-bit registers), pointer, fill counter and accumulator.
  - Outputs avg and a `filled` indication.
- `ad_weight` contains the FSM, tare register, scaling pipeline and stability logic.

## Test plan
Bench configuration: AVG_LOG2=2, SCALE_NUM=1, SCALE_SHIFT=0, STABLE_TH=2, STABLE_CNT=3.
- **Fill:** 4 samples of 100 → no weight_valid for the first 3 samples; after the 4th, weight_g = 100, 3 cycles after that sample's raw_valid.
- **Averaging:** after fill at 100, samples 200, 200 → weight_g = 125, then 150.
- **Tare:** steady input 1000, then tare_req → tare_busy high and weight_valid suppressed for 4 samples; the next output is weight_g = 0. Input 1010 → outputs rise toward 10.
- **Clamp and overload:**
  - With tare = 1000, input 900 → weight_g = 0, overload = 0.
  - With SCALE_NUM=16'd100, input 1000 and tare 0 → weight_g = 65535, overload = 1.
- **Stability:** constant input → stable = 1 after the 3rd weight_valid; a step of +50 → stable = 0 on the next update.
- **Reset mid-TARE:** assert rst while tare_busy = 1 → all outputs return to 0, FSM is in FILL, and tare = 0.
